// File: rtl/dl166_pkg.sv
// dl166_pkg
// Shared definitions for the DL166 program-memory loader and any CPU-side
// bench that needs the same address/instruction widths.
//   ADR_W    : CPU fetch address width
//   INSN_W   : instruction and loader byte width
//   DEPTH    : number of instruction words (2**ADR_W)
//   CNT_W    : width of the loader word counter, wide enough to hold DEPTH
//   NOP_INSN : encoding of MOV r0,r0, used to pad unloaded words
//   ldState_t: loader FSM states
package dl166_pkg;

  localparam int ADR_W  = 4;
  localparam int INSN_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  localparam logic [INSN_W-1:0] NOP_INSN = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_FILL = 3'd3,
    ST_SUM  = 3'd4,
    ST_RUN  = 3'd5,
    ST_ERR  = 3'd6
  } ldState_t;

  // The loader only takes bytes while it is expecting the length, a data
  // byte or the checksum; everywhere else a presented byte stays unconsumed.
  function automatic logic isByteState(input ldState_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_SUM);
  endfunction

endpackage

// File: rtl/dl166_prog_ram.sv
// dl166_prog_ram
// 16 x 8 instruction store. Writes land on the rising clock edge, reads are
// purely combinational so the CPU sees its instruction in the same cycle
// it presents the address.
//   clk       : clock
//   i_clear_n : synchronous active-low clear of every word to zero
//   i_we      : write enable
//   i_waddr   : write address
//   i_wdata   : write data
//   i_raddr   : read address
//   o_rdata   : word at i_raddr
module dl166_prog_ram
  import dl166_pkg::*;
(
  input  logic              clk,
  input  logic              i_clear_n,
  input  logic              i_we,
  input  logic [ADR_W-1:0]  i_waddr,
  input  logic [INSN_W-1:0] i_wdata,
  input  logic [ADR_W-1:0]  i_raddr,
  output logic [INSN_W-1:0] o_rdata
);

  logic [INSN_W-1:0] r_mem [DEPTH];

  // Clear wins over a write so a reset in the middle of a load never leaves
  // a half-written program behind.
  always_ff @(posedge clk) begin
    if (!i_clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dl166_prog_loader.sv
// dl166_prog_loader
// Program-memory responder for the DL166 CPU. Answers the CPU fetch address
// with the stored instruction combinationally and fills the store from a
// valid/ready byte stream of the form: length, data bytes, checksum. The CPU
// is held in reset until a load finishes with a matching checksum.
//   clk           : clock
//   reset         : synchronous active-low reset
//   i_cpu_adr     : CPU fetch address
//   o_cpu_dout    : instruction at i_cpu_adr
//   o_cpu_reset_n : registered reset to the CPU, 0 holds it in reset
//   i_load_start  : single-cycle request to begin a load
//   i_ld_valid    : loader byte valid
//   i_ld_data     : loader byte
//   o_ld_ready    : a byte is accepted this cycle when valid
//   o_load_done   : high while a good program is running
//   o_load_err    : high after a bad length or checksum
//   o_checksum    : running mod-256 sum of accepted data bytes
module dl166_prog_loader
  import dl166_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  i_cpu_adr,
  output logic [INSN_W-1:0] o_cpu_dout,
  output logic              o_cpu_reset_n,
  input  logic              i_load_start,
  input  logic              i_ld_valid,
  input  logic [INSN_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [INSN_W-1:0] o_checksum
);

  ldState_t          r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_len;
  logic [INSN_W-1:0] r_checksum;
  logic              r_cpuResetN;

  ldState_t          w_nextState;
  logic [CNT_W-1:0]  w_nextCount;
  logic [CNT_W-1:0]  w_nextLen;
  logic [INSN_W-1:0] w_nextChecksum;
  logic              w_nextCpuResetN;
  logic              w_ldReady;
  logic              w_xfer;
  logic              w_lenOk;
  logic              w_ramWe;
  logic [ADR_W-1:0]  w_ramWaddr;
  logic [INSN_W-1:0] w_ramWdata;

  // Ready is a function of state alone so the loader side can never form a
  // combinational loop through valid.
  assign w_ldReady = isByteState(r_state);
  assign w_xfer    = i_ld_valid && w_ldReady;
  assign w_lenOk   = (i_ld_data != '0) && (i_ld_data <= INSN_W'(DEPTH));

  // State and loader bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_len       <= '0;
      r_checksum  <= '0;
      r_cpuResetN <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_count     <= w_nextCount;
      r_len       <= w_nextLen;
      r_checksum  <= w_nextChecksum;
      r_cpuResetN <= w_nextCpuResetN;
    end
  end

  // Next-state logic. The word counter doubles as the RAM write pointer for
  // both DATA and FILL, so FILL simply carries on from where DATA stopped
  // and pads the rest of the store with NOPs up to the last word.
  always_comb begin
    w_nextState     = r_state;
    w_nextCount     = r_count;
    w_nextLen       = r_len;
    w_nextChecksum  = r_checksum;
    w_nextCpuResetN = r_cpuResetN;
    w_ramWe         = 1'b0;
    w_ramWaddr      = r_count[ADR_W-1:0];
    w_ramWdata      = i_ld_data;

    case (r_state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (i_load_start) begin
          w_nextState     = ST_LEN;
          w_nextCpuResetN = 1'b0;
          w_nextChecksum  = '0;
          w_nextCount     = '0;
        end
      end

      ST_LEN: begin
        if (w_xfer) begin
          if (w_lenOk) begin
            w_nextLen   = i_ld_data[CNT_W-1:0];
            w_nextState = ST_DATA;
          end else begin
            w_nextState = ST_ERR;
          end
        end
      end

      ST_DATA: begin
        if (w_xfer) begin
          w_ramWe        = 1'b1;
          w_nextCount    = r_count + 1'b1;
          w_nextChecksum = r_checksum + i_ld_data;
          if ((r_count + 1'b1) == r_len) begin
            w_nextState = (r_len == CNT_W'(DEPTH)) ? ST_SUM : ST_FILL;
          end
        end
      end

      ST_FILL: begin
        w_ramWe     = 1'b1;
        w_ramWdata  = NOP_INSN;
        w_nextCount = r_count + 1'b1;
        if (r_count == CNT_W'(DEPTH - 1)) begin
          w_nextState = ST_SUM;
        end
      end

      ST_SUM: begin
        if (w_xfer) begin
          if (i_ld_data == r_checksum) begin
            w_nextState     = ST_RUN;
            w_nextCpuResetN = 1'b1;
          end else begin
            w_nextState = ST_ERR;
          end
        end
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  dl166_prog_ram u_ram (
    .clk       (clk),
    .i_clear_n (reset),
    .i_we      (w_ramWe),
    .i_waddr   (w_ramWaddr),
    .i_wdata   (w_ramWdata),
    .i_raddr   (i_cpu_adr),
    .o_rdata   (o_cpu_dout)
  );

  assign o_cpu_reset_n = r_cpuResetN;
  assign o_ld_ready    = w_ldReady;
  assign o_load_done   = (r_state == ST_RUN);
  assign o_load_err    = (r_state == ST_ERR);
  assign o_checksum    = r_checksum;

endmodule

// File: tb/tb_dl166_prog_loader.sv
// tb_dl166_prog_loader
// Directed bench for the DL166 program loader. A reference image of the
// instruction store is kept alongside the stimulus; its words are queued as
// expected fetch results and drained by reading the DUT through the CPU port.
module tb_dl166_prog_loader;
  import dl166_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADR_W-1:0]  i_cpu_adr;
  logic [INSN_W-1:0] o_cpu_dout;
  logic              o_cpu_reset_n;
  logic              i_load_start;
  logic              i_ld_valid;
  logic [INSN_W-1:0] i_ld_data;
  logic              o_ld_ready;
  logic              o_load_done;
  logic              o_load_err;
  logic [INSN_W-1:0] o_checksum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADR_W-1:0]  adr;
    logic [INSN_W-1:0] data;
  } ramExp_t;

  ramExp_t           sb[$];
  logic [INSN_W-1:0] expRam [DEPTH];
  logic [INSN_W-1:0] expSum;
  int                fillCnt;

  dl166_prog_loader dut (
    .clk           (clk),
    .reset         (reset),
    .i_cpu_adr     (i_cpu_adr),
    .o_cpu_dout    (o_cpu_dout),
    .o_cpu_reset_n (o_cpu_reset_n),
    .i_load_start  (i_load_start),
    .i_ld_valid    (i_ld_valid),
    .i_ld_data     (i_ld_data),
    .o_ld_ready    (o_ld_ready),
    .o_load_done   (o_load_done),
    .o_load_err    (o_load_err),
    .o_checksum    (o_checksum)
  );

  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is ever mis-sized.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one byte and holds it until the DUT takes it, bounded.
  task automatic applyStimulus(input logic [INSN_W-1:0] b);
    int waitCnt;
    waitCnt = 0;
    i_ld_valid = 1'b1;
    i_ld_data  = b;
    while (!o_ld_ready && waitCnt < 40) begin
      tick();
      waitCnt++;
    end
    checkOutput("ld_ready_wait", o_ld_ready, 1);
    tick();
    i_ld_valid = 1'b0;
  endtask

  task automatic pulseStart();
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic waitFill(output int n);
    n = 0;
    while (!o_ld_ready && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic pushRamModel();
    ramExp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.adr  = ADR_W'(i);
      e.data = expRam[i];
      sb.push_back(e);
    end
  endtask

  task automatic drainRam();
    ramExp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      i_cpu_adr = e.adr;
      #1;
      checkOutput($sformatf("ram[%0d]", e.adr), o_cpu_dout, e.data);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) expRam[i] = 8'h00;
  endtask

  initial begin
    reset        = 1'b0;
    i_cpu_adr    = '0;
    i_load_start = 1'b0;
    i_ld_valid   = 1'b0;
    i_ld_data    = '0;
    clearModel();
    tick();
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_cpu_reset_n", o_cpu_reset_n, 0);
    checkOutput("rst_ld_ready", o_ld_ready, 0);
    checkOutput("rst_load_done", o_load_done, 0);
    checkOutput("rst_load_err", o_load_err, 0);
    checkOutput("rst_checksum", o_checksum, 8'h00);
    pushRamModel();
    drainRam();

    $display("[TB] full load N=16");
    pulseStart();
    checkOutput("full_ready_after_start", o_ld_ready, 1);
    applyStimulus(8'h10);
    expSum = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(8'(i + 1));
      expRam[i] = 8'(i + 1);
      expSum    = expSum + 8'(i + 1);
    end
    checkOutput("full_no_fill_ready", o_ld_ready, 1);
    checkOutput("full_checksum", o_checksum, 8'h88);
    checkOutput("full_model_sum", expSum, o_checksum);
    checkOutput("full_cpu_held", o_cpu_reset_n, 0);
    applyStimulus(8'h88);
    checkOutput("full_cpu_reset_n", o_cpu_reset_n, 1);
    checkOutput("full_load_done", o_load_done, 1);
    checkOutput("full_ready_run", o_ld_ready, 0);
    i_cpu_adr = 4'hF;
    #1;
    checkOutput("full_dout_F", o_cpu_dout, 8'h10);
    pushRamModel();
    drainRam();

    $display("[TB] restart from RUN and partial load N=3");
    pulseStart();
    checkOutput("restart_cpu_reset_n", o_cpu_reset_n, 0);
    checkOutput("restart_load_done", o_load_done, 0);
    checkOutput("restart_ready", o_ld_ready, 1);
    checkOutput("restart_checksum", o_checksum, 8'h00);
    i_cpu_adr = 4'h0;
    #1;
    checkOutput("restart_ram_intact", o_cpu_dout, 8'h01);
    applyStimulus(8'h03);
    applyStimulus(8'h90);
    expRam[0] = 8'h90;
    i_cpu_adr = 4'h0;
    #1;
    checkOutput("partial_write_visible", o_cpu_dout, 8'h90);
    pulseStart();
    checkOutput("start_in_data_ready", o_ld_ready, 1);
    checkOutput("start_in_data_sum", o_checksum, 8'h90);
    applyStimulus(8'hA5);
    expRam[1] = 8'hA5;
    tick();
    tick();
    tick();
    checkOutput("gap_ready", o_ld_ready, 1);
    checkOutput("gap_sum", o_checksum, 8'h35);
    applyStimulus(8'h48);
    expRam[2] = 8'h48;
    waitFill(fillCnt);
    checkOutput("partial_fill_cycles", fillCnt, 13);
    for (int i = 3; i < DEPTH; i++) expRam[i] = NOP_INSN;
    checkOutput("partial_checksum", o_checksum, 8'h7D);
    applyStimulus(8'h7D);
    checkOutput("partial_cpu_reset_n", o_cpu_reset_n, 1);
    checkOutput("partial_load_done", o_load_done, 1);
    pushRamModel();
    drainRam();

    $display("[TB] bad checksum");
    pulseStart();
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    expRam[0] = 8'h11;
    expRam[1] = 8'h22;
    waitFill(fillCnt);
    checkOutput("badsum_fill_cycles", fillCnt, 14);
    for (int i = 2; i < DEPTH; i++) expRam[i] = NOP_INSN;
    applyStimulus(8'h00);
    checkOutput("badsum_load_err", o_load_err, 1);
    checkOutput("badsum_cpu_reset_n", o_cpu_reset_n, 0);
    checkOutput("badsum_load_done", o_load_done, 0);
    checkOutput("badsum_ready", o_ld_ready, 0);
    pushRamModel();
    drainRam();

    $display("[TB] bad length 00 and 11");
    pulseStart();
    checkOutput("badlen0_ready", o_ld_ready, 1);
    applyStimulus(8'h00);
    checkOutput("badlen0_err", o_load_err, 1);
    checkOutput("badlen0_ready_after", o_ld_ready, 0);
    pushRamModel();
    drainRam();
    pulseStart();
    checkOutput("badlen11_left_err", o_load_err, 0);
    applyStimulus(8'h11);
    checkOutput("badlen11_err", o_load_err, 1);
    checkOutput("badlen11_ready_after", o_ld_ready, 0);
    checkOutput("badlen11_cpu_reset_n", o_cpu_reset_n, 0);
    i_ld_valid = 1'b1;
    i_ld_data  = 8'h05;
    tick();
    tick();
    i_ld_valid = 1'b0;
    checkOutput("err_valid_ignored", o_load_err, 1);
    pushRamModel();
    drainRam();

    $display("[TB] reset mid-load");
    pulseStart();
    applyStimulus(8'h04);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    i_cpu_adr = 4'h1;
    #1;
    checkOutput("midload_written", o_cpu_dout, 8'hBB);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    clearModel();
    checkOutput("midrst_ready", o_ld_ready, 0);
    checkOutput("midrst_cpu_reset_n", o_cpu_reset_n, 0);
    checkOutput("midrst_load_err", o_load_err, 0);
    checkOutput("midrst_checksum", o_checksum, 8'h00);
    pushRamModel();
    drainRam();

    $display("[TB] single-word load after reset");
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h5A);
    expRam[0] = 8'h5A;
    waitFill(fillCnt);
    checkOutput("single_fill_cycles", fillCnt, 15);
    applyStimulus(8'h5A);
    checkOutput("single_load_done", o_load_done, 1);
    checkOutput("single_cpu_reset_n", o_cpu_reset_n, 1);
    pushRamModel();
    drainRam();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dl166_prog_loader.md
# dl166_prog_loader

Program-memory responder for the DL166 4-bit CPU: the far end of the CPU's instruction-fetch interface. It holds a 16 x 8 instruction RAM and answers the CPU's 4-bit fetch address with the 8-bit instruction on the same cycle. A byte-stream loader port with a valid/ready handshake fills the RAM in the form length, data bytes, checksum. The block holds the CPU in reset until a load completes with a matching checksum.

## Interface
- ADR_W, 4, fetch address width; RAM depth is 2**ADR_W = 16
- INSN_W, 8, instruction and loader byte width
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-low
- cpu_adr  in  ADR_W  CPU fetch address (CPU PC)
- cpu_dout  out  INSN_W  instruction at cpu_adr, combinational read
- cpu_reset_n  out  1  registered reset to CPU; 0 holds the CPU in reset
- load_start  in  1  single-cycle request to begin a load
- ld_valid  in  1  ld_data is valid
- ld_data  in  INSN_W  loader byte
- ld_ready  out  1  block accepts a byte this cycle
- load_done  out  1  level; high while in RUN
- load_err  out  1  level; high while in ERR
- checksum  out  INSN_W  running mod-256 sum of accepted data bytes

## Operation
- States: IDLE, LEN, DATA, FILL, SUM, RUN, ERR.
- A transfer occurs on a posedge with ld_valid && ld_ready.
- ld_ready is 1 only in LEN, DATA and SUM. It is combinational from state only and never depends on ld_valid.
- IDLE/RUN/ERR + load_start -> LEN. On the same edge: cpu_reset_n <= 0, checksum <= 0, word count <= 0.
- In LEN, DATA, FILL and SUM, load_start is ignored.
- LEN: the accepted byte is N.
  - N in 1..16: latch N and go to DATA.
  - N = 0 or N > 16: go to ERR; RAM unchanged.
- DATA: each accepted byte is written to RAM[count]; count += 1; checksum += byte (mod 256).
  - After byte N: if N < 16, go to FILL at address N; otherwise go to SUM.
- FILL: write 8'h00 to one address per cycle, from N through 15, then go to SUM. Unused locations become MOV r0,r0, a NOP.
- SUM: compare the accepted byte with checksum.
  - Equal: go to RUN; cpu_reset_n <= 1 on that edge.
  - Not equal: go to ERR; cpu_reset_n stays 0.
- RUN: the CPU executes. The RAM is read-only to the CPU.
- cpu_dout = RAM[cpu_adr] in every state, including during a load.
- Address wrap: cpu_adr is ADR_W bits and wraps naturally at 15 -> 0; no range check is needed.

## Timing
- Reset (reset == 0 at posedge) overrides everything. Reset values:
  - state = IDLE
  - all 16 RAM words = 8'h00, so cpu_dout = 8'h00
  - cpu_reset_n = 0, ld_ready = 0, load_done = 0, load_err = 0, checksum = 0
- Reset asserted mid-load aborts the load. RAM is cleared and the CPU is held in reset.
- Latencies:
  - load_start at edge k: ld_ready = 1 from cycle k+1.
  - Each of LEN, DATA and SUM accepts at most one byte per cycle, back-to-back with no gap.
  - A DATA write is visible on cpu_dout in the cycle after the accepting edge.
  - FILL takes exactly 16 - N cycles, with ld_ready = 0 throughout.
  - Checksum-accept edge k: cpu_reset_n = 1 and load_done = 1 from cycle k+1.
- Best-case full load with N = 16: 1 + 16 + 1 = 18 accepted bytes, no FILL.
- load_start during RUN re-enters LEN. cpu_reset_n falls on that edge and the CPU halts before any RAM write.
- ld_valid outside LEN/DATA/SUM is ignored and the byte is not consumed.

## Structure
- Shared package dl166_pkg holds:
  - ADR_W, INSN_W, DEPTH = 16
  - NOP_INSN = 8'h00
  - the loader state enum (7 states, 3-bit encoding)
- The same package is usable by the CPU-side bench.
- Sub-module dl166_prog_ram: 16 x 8 register array with synchronous write (we, waddr, wdata), asynchronous read (raddr -> rdata), and a synchronous active-low clear.
- The top level holds the FSM, count, N, checksum and cpu_reset_n registers.

## Test plan
- Reset, then check outputs -> cpu_dout = 00 for every cpu_adr 0..15; cpu_reset_n = 0; ld_ready = 0; load_done = 0.
- Partial load: load_start, then bytes 03, 90, A5, 48 (checksum 7D), then 7D -> RAM[0..2] = 90 A5 48; RAM[3..15] = 00 after exactly 13 FILL cycles; cpu_reset_n = 1 one cycle after 7D is accepted; load_done = 1.
- Full load: N = 10 (hex), 16 bytes 01..10, checksum 88 -> no FILL cycles; RUN; cpu_dout at cpu_adr F = 10.
- Bad checksum: 02, 11, 22, then 00 -> ERR; load_err = 1; cpu_reset_n = 0; RAM[0..1] = 11, 22.
- Bad length: 00, then separately 11 -> ERR immediately on the length byte; RAM untouched; ld_ready = 0.
- Interruptions:
  - load_start during DATA -> ignored.
  - load_start during RUN -> cpu_reset_n = 0 next cycle.
  - reset after the second DATA byte -> all RAM = 00; IDLE.
  - ld_valid held low for 3 cycles mid-DATA -> no byte skipped or duplicated.
